pwm_duty_ramp: RTL

Brightness ramp controller that sits directly upstream of the PWM stage in the OLED controller. It accepts an 8-bit target brightness level over a valid/ready handshake. It steps the current level toward the target one unit at a time at a programmable rate, converts each level into a high/low phase-length pair for the PWM, and commits new pairs only at a PWM high-phase boundary so the PWM counters never overshoot.

---
 rtl/pwm_duty_ramp_pkg.sv | 29 ++
 rtl/pwm_duty_ramp_mul16x8_seq.sv | 69 ++++++
 rtl/pwm_duty_ramp.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_pkg.sv
// Shared types for the OLED brightness path.
// Phase lengths, brightness levels and the ramp FSM states.
package MyPkg;

    typedef logic [15:0] byte2_t;
    typedef logic [7:0]  level_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CALC,
        COMMIT
    } ramp_state_t;

    // Keep both PWM phases at least two cycles long.
    localparam byte2_t PHASE_MIN = 16'd2;

    function automatic byte2_t clamp_phase(input byte2_t raw, input byte2_t period);
        byte2_t hi;
        hi = period - PHASE_MIN;
        if (raw < PHASE_MIN) begin
            return PHASE_MIN;
        end else if (raw > hi) begin
            return hi;
        end
        return raw;
    endfunction

endpackage

// File: rtl/pwm_duty_ramp_mul16x8_seq.sv
// Sequential shift-add 16x8 multiplier, MSB of B first.
// The product is valid when done pulses, 8 cycles after start.
module mul16x8_seq
    import MyPkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic [23:0] prod,
    output logic        done
);

    logic [23:0] acc_q, acc_d;
    logic [15:0] a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic        done_q, done_d;

    // Start consumes B[7] immediately; the remaining seven bits follow.
    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            acc_d = b[7] ? {8'd0, a} : 24'd0;
            a_d   = a;
            b_d   = {b[6:0], 1'b0};
            cnt_d = 3'd7;
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = {acc_q[22:0], 1'b0} + (b_q[7] ? {8'd0, a_q} : 24'd0);
            b_d   = {b_q[6:0], 1'b0};
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign prod = acc_q;
    assign done = done_q;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Brightness ramp in front of the PWM: steps toward a target level and
// commits new high/low phase pairs only on a PWM rising edge.
module pwm_duty_ramp
    import MyPkg::*;
#(
    parameter byte2_t      PERIOD   = 16'd1000,
    parameter logic [31:0] STEP_DIV = 32'd50000
) (
    input  logic   clk,
    input  logic   rst_n,
    input  level_t tgt_level,
    input  logic   tgt_valid,
    output logic   tgt_ready,
    input  logic   pwm_pulse,
    output byte2_t t_high,
    output byte2_t t_low,
    output level_t cur_level,
    output logic   busy,
    output logic   done
);

    ramp_state_t state_q, state_d;
    level_t      target_q, target_d;
    level_t      cur_q, cur_d;
    level_t      next_q, next_d;
    logic [31:0] timer_q, timer_d;
    logic        pulse_q, pulse_d;
    byte2_t      th_q, th_d;
    byte2_t      tl_q, tl_d;
    byte2_t      hp_q, hp_d;
    byte2_t      lp_q, lp_d;
    logic        done_q, done_d;

    logic        hs;
    logic        rise;
    level_t      tgt_eff;
    logic        mul_start;
    logic        mul_done;
    logic [23:0] prod;
    byte2_t      h_clamp;
    logic        unused_prod_lsb;

    mul16x8_seq u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (PERIOD),
        .b     (next_d),
        .prod  (prod),
        .done  (mul_done)
    );

    assign unused_prod_lsb = ^prod[7:0];
    assign h_clamp         = clamp_phase(prod[23:8], PERIOD);
    assign tgt_ready       = (state_q == IDLE) || (state_q == WAIT);
    assign hs              = tgt_valid & tgt_ready;
    assign rise            = pwm_pulse & ~pulse_q;
    assign tgt_eff         = hs ? tgt_level : target_q;

    // Next-state and datapath updates for the ramp FSM.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        cur_d     = cur_q;
        next_d    = next_q;
        timer_d   = timer_q;
        pulse_d   = pwm_pulse;
        th_d      = th_q;
        tl_d      = tl_q;
        hp_d      = hp_q;
        lp_d      = lp_q;
        done_d    = 1'b0;
        mul_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    target_d = tgt_level;
                    if (tgt_level != cur_q) begin
                        timer_d = '0;
                        state_d = WAIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                target_d = tgt_eff;
                if (tgt_eff == cur_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timer_q == STEP_DIV - 32'd1) begin
                    next_d    = (tgt_eff > cur_q) ? cur_q + 8'd1 : cur_q - 8'd1;
                    mul_start = 1'b1;
                    state_d   = CALC;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            CALC: begin
                if (mul_done) begin
                    hp_d    = h_clamp;
                    lp_d    = PERIOD - h_clamp;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (rise) begin
                    th_d  = hp_q;
                    tl_d  = lp_q;
                    cur_d = next_q;
                    if (next_q == target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer and output registers; reset keeps t_high + t_low == PERIOD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            cur_q    <= '0;
            next_q   <= '0;
            timer_q  <= '0;
            pulse_q  <= 1'b1;
            th_q     <= PHASE_MIN;
            tl_q     <= PERIOD - PHASE_MIN;
            hp_q     <= PHASE_MIN;
            lp_q     <= PERIOD - PHASE_MIN;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            next_q   <= next_d;
            timer_q  <= timer_d;
            pulse_q  <= pulse_d;
            th_q     <= th_d;
            tl_q     <= tl_d;
            hp_q     <= hp_d;
            lp_q     <= lp_d;
            done_q   <= done_d;
        end
    end

    assign t_high    = th_q;
    assign t_low     = tl_q;
    assign cur_level = cur_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
